// File: rtl/keccak_absorb_buffer_if.sv
// Padder-to-permutation bundle: lane stream from the padder in, rate block out.
// The master drives the lane stream and blk_ready; the slave (the absorb buffer) drives the rest.
interface keccak_absorb_buffer_if #(
    parameter int LANE_W    = 64,
    parameter int MAX_LANES = 21,
    parameter int CNT_W     = $clog2(MAX_LANES + 1)
);
    logic [1:0]                  mode;
    logic [LANE_W-1:0]           in_lane;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [LANE_W*MAX_LANES-1:0] blk_data;
    logic                        blk_valid;
    logic                        blk_last;
    logic                        blk_ready;
    logic [CNT_W-1:0]            lane_cnt;

    modport master (
        output mode, in_lane, in_valid, in_last, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_last, lane_cnt
    );

    modport slave (
        input  mode, in_lane, in_valid, in_last, blk_ready,
        output in_ready, blk_data, blk_valid, blk_last, lane_cnt
    );
endinterface

// File: rtl/keccak_absorb_buffer.sv
// Keccak rate-block assembler: packs padded lanes into a 9/13/17/18-lane block, zero-extended to 21 lanes.
// Latency: lane written on its transfer edge; blk_valid rises on the edge accepting the block's last lane.
// Backpressure: in_ready drops while no bank can fill (single bank, or both banks with KECCAK_ABSORB_DOUBLE_BUF_EN).
module keccak_absorb_buffer #(
    parameter int LANE_W    = 64,
    parameter int MAX_LANES = 21
) (
    input logic                  clk,
    input logic                  rst,
    keccak_absorb_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LANES + 1);
`ifdef KECCAK_ABSORB_DOUBLE_BUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state_q [NBANK];
    state_t            state_d [NBANK];
    logic [LANE_W-1:0] bank_q  [NBANK][MAX_LANES];
    logic              last_q  [NBANK];
    logic              wr_sel_q;
    logic              rd_sel_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0]        cur_mode;
    logic              close;
    logic              xfer;
    logic              hs;

    function automatic logic [CNT_W-1:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    return CNT_W'(9);
            2'd1:    return CNT_W'(13);
            2'd2:    return CNT_W'(17);
            default: return CNT_W'(18);
        endcase
    endfunction

    // The first lane of a block takes the live mode; later lanes use the one latched with it.
    assign cur_mode = (cnt_q == '0) ? bus.mode : mode_q;
    assign close    = (cnt_q == rate_of(cur_mode) - CNT_W'(1));

    assign bus.in_ready  = (state_q[wr_sel_q] == FILL);
    assign bus.blk_valid = (state_q[rd_sel_q] == FULL);
    assign bus.blk_last  = last_q[rd_sel_q];
    assign bus.lane_cnt  = cnt_q;

    assign xfer = bus.in_valid & bus.in_ready;
    assign hs   = bus.blk_valid & bus.blk_ready;

    always_comb begin
        bus.blk_data = '0;
        for (int l = 0; l < MAX_LANES; l++) begin
            bus.blk_data[l*LANE_W +: LANE_W] = bank_q[rd_sel_q][l];
        end
    end

    // Fill and drain always target different banks, so both updates can apply together.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            state_d[b] = state_q[b];
        end
        if (xfer && close) begin
            state_d[wr_sel_q] = FULL;
        end
        if (hs) begin
            state_d[rd_sel_q] = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NBANK; b++) begin
                state_q[b] <= FILL;
                last_q[b]  <= 1'b0;
                for (int l = 0; l < MAX_LANES; l++) begin
                    bank_q[b][l] <= '0;
                end
            end
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            mode_q   <= 2'd0;
            cnt_q    <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                state_q[b] <= state_d[b];
            end

            if (xfer) begin
                bank_q[wr_sel_q][cnt_q] <= bus.in_lane;
                if (cnt_q == '0) begin
                    mode_q <= bus.mode;
                end
                if (close) begin
                    cnt_q            <= '0;
                    last_q[wr_sel_q] <= bus.in_last;
                    if (NBANK == 2) begin
                        wr_sel_q <= ~wr_sel_q;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // A drained bank is zeroed so lanes beyond a shorter rate never leak old data.
            if (hs) begin
                for (int l = 0; l < MAX_LANES; l++) begin
                    bank_q[rd_sel_q][l] <= '0;
                end
                last_q[rd_sel_q] <= 1'b0;
                if (NBANK == 2) begin
                    rd_sel_q <= ~rd_sel_q;
                end
            end
        end
    end
endmodule
